// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: word type, store-size encodings
// and the default buffer depth.
package store_buffer_pkg;
  typedef logic [31:0] word;

  localparam logic [1:0] st_b = 2'b00;
  localparam logic [1:0] st_h = 2'b01;
  localparam logic [1:0] st_w = 2'b10;

  localparam int default_depth = 4;
endpackage

// File: rtl/store_buffer_if.sv
// Data-memory write port: the buffer presents its head entry, memory accepts it.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic       mem_write_valid;
  logic       mem_write_ready;
  word        mem_write_addr;
  word        mem_write_data;
  logic [3:0] mem_write_byte_enable;

  modport master (
    output mem_write_valid, mem_write_addr, mem_write_data, mem_write_byte_enable,
    input  mem_write_ready
  );

  modport slave (
    input  mem_write_valid, mem_write_addr, mem_write_data, mem_write_byte_enable,
    output mem_write_ready
  );
endinterface

// File: rtl/store_buffer_align.sv
// Combinational store alignment: lane replication, byte enables and the
// misalignment / illegal-type check.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [1:0] store_type,
  input  logic [1:0] addr_lo,
  input  word        rs2,
  output word        data,
  output logic [3:0] be,
  output logic       error
);

  always_comb begin
    data  = '0;
    be    = '0;
    error = 1'b0;
    case (store_type)
      st_b: begin
        data = {4{rs2[7:0]}};
        be   = 4'b0001 << addr_lo;
      end
      st_h: begin
        data  = {2{rs2[15:0]}};
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        error = addr_lo[0];
      end
      st_w: begin
        data  = rs2;
        be    = 4'b1111;
        error = |addr_lo;
      end
      default: error = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: aligns pipeline stores, queues them and drains them to
// data memory, flagging loads that hit a word still waiting in the queue.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = default_depth
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       store_valid,
  input  logic [1:0] store_type,
  input  word        alu_output,
  input  word        rs2_read,
  output logic       store_stall,
  output logic       store_error,
  input  logic       load_valid,
  input  word        load_addr,
  output logic       load_conflict,
  output logic       buffer_empty,
  store_buffer_if.master mem
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [29:0]      ent_addr [DEPTH];
  word              ent_data [DEPTH];
  logic [3:0]       ent_be   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             err_p1;

  word              al_data;
  logic [3:0]       al_be;
  logic             al_err;
  logic             head_vld, enq, deq;
  word              load_word;
  logic [PTR_W-1:0] off;

  store_align u_align (
    .store_type (store_type),
    .addr_lo    (alu_output[1:0]),
    .rs2        (rs2_read),
    .data       (al_data),
    .be         (al_be),
    .error      (al_err)
  );

  // Stall looks only at registered occupancy; a dequeue this cycle does not free a slot early.
  assign store_stall  = (count == CNT_W'(DEPTH));
  assign head_vld     = (count != '0);
  assign buffer_empty = ~head_vld;
  assign store_error  = err_p1;
  assign enq          = store_valid & ~store_stall & ~al_err;
  assign deq          = head_vld & mem.mem_write_ready;

  assign mem.mem_write_valid       = head_vld;
  assign mem.mem_write_addr        = {ent_addr[rd_ptr], 2'b00};
  assign mem.mem_write_data        = ent_data[rd_ptr];
  assign mem.mem_write_byte_enable = ent_be[rd_ptr];

  // Word-granular match against live entries only; byte lanes are ignored on purpose.
  assign load_word = load_addr & ~word'(3);

  always_comb begin
    load_conflict = 1'b0;
    off           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (({1'b0, off} < count) && ({ent_addr[i], 2'b00} == load_word))
        load_conflict = load_valid;
    end
  end

  // Stage p1: entry storage, written on enqueue and never reset
  always_ff @(posedge clock) begin
    if (enq) begin
      ent_addr[wr_ptr] <= alu_output[31:2];
      ent_data[wr_ptr] <= al_data;
      ent_be[wr_ptr]   <= al_be;
    end
  end

  // Stage p1: queue control and the one-cycle error pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= store_valid & al_err;
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
